// File: rtl/bcd_frame_transmitter.sv
// BCD link line encoder: emits an HO frame marker, then serialises WORDS 16-bit words
// MSB-first as IM1 ('1') / IM0 ('0') pulses, each followed by an all-low gap.
module bcd_frame_transmitter #(
    parameter int WORDS     = 96,
    parameter int HO_LEN    = 48,
    parameter int PULSE_LEN = 48,
    parameter int GAP_LEN   = 48
) (
    input  logic        clk13MHz,
    input  logic        nRST,
    input  logic        start,
    input  logic [15:0] din,
    output logic        rdReq,
    output logic [6:0]  rdAddr,
    output logic        HO,
    output logic        IM1,
    output logic        IM0,
    output logic        busy,
    output logic        frameDone
);

    typedef enum logic [2:0] {
        IDLE,
        SYNC,
        SGAP,
        FETCH,
        LOAD,
        PULSE,
        BGAP,
        DONE
    } state_t;

    localparam logic [11:0] HO_LAST    = 12'(HO_LEN - 1);
    localparam logic [11:0] PULSE_LAST = 12'(PULSE_LEN - 1);
    localparam logic [11:0] GAP_LAST   = 12'(GAP_LEN - 1);
    localparam logic [6:0]  WORD_LAST  = 7'(WORDS - 1);

    state_t      state, state_nxt;
    logic [11:0] cnt, cnt_nxt;
    logic [3:0]  bitCnt, bitCnt_nxt;
    logic [6:0]  wordCnt, wordCnt_nxt;
    logic [15:0] shreg, shreg_nxt;

    // Control state; nRST is active-high despite its name.
    always_ff @(posedge clk13MHz) begin
        if (nRST) begin
            state   <= IDLE;
            cnt     <= '0;
            bitCnt  <= '0;
            wordCnt <= '0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            bitCnt  <= bitCnt_nxt;
            wordCnt <= wordCnt_nxt;
        end
    end

    always_ff @(posedge clk13MHz) begin
        shreg <= shreg_nxt;
    end

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt + 12'd1;
        bitCnt_nxt  = bitCnt;
        wordCnt_nxt = wordCnt;
        shreg_nxt   = shreg;
        case (state)
            IDLE: begin
                cnt_nxt     = '0;
                wordCnt_nxt = '0;
                if (start) state_nxt = SYNC;
            end
            SYNC: begin
                if (cnt == HO_LAST) begin
                    cnt_nxt   = '0;
                    state_nxt = SGAP;
                end
            end
            SGAP: begin
                if (cnt == GAP_LAST) begin
                    cnt_nxt     = '0;
                    wordCnt_nxt = '0;
                    state_nxt   = FETCH;
                end
            end
            FETCH: begin
                cnt_nxt   = '0;
                state_nxt = LOAD;
            end
            LOAD: begin
                cnt_nxt    = '0;
                bitCnt_nxt = '0;
                shreg_nxt  = din;
                state_nxt  = PULSE;
            end
            PULSE: begin
                if (cnt == PULSE_LAST) begin
                    cnt_nxt   = '0;
                    state_nxt = BGAP;
                end
            end
            BGAP: begin
                if (cnt == GAP_LAST) begin
                    cnt_nxt    = '0;
                    shreg_nxt  = {shreg[14:0], 1'b0};
                    bitCnt_nxt = bitCnt + 4'd1;
                    if (bitCnt != 4'd15) begin
                        state_nxt = PULSE;
                    end else if (wordCnt != WORD_LAST) begin
                        wordCnt_nxt = wordCnt + 7'd1;
                        state_nxt   = FETCH;
                    end else begin
                        state_nxt = DONE;
                    end
                end
            end
            DONE: begin
                cnt_nxt     = '0;
                wordCnt_nxt = '0;
                state_nxt   = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs are registered from the next state so each line tracks its state exactly.
    always_ff @(posedge clk13MHz) begin
        if (nRST) begin
            HO        <= 1'b0;
            IM1       <= 1'b0;
            IM0       <= 1'b0;
            rdReq     <= 1'b0;
            rdAddr    <= '0;
            busy      <= 1'b0;
            frameDone <= 1'b0;
        end else begin
            HO        <= (state_nxt == SYNC);
            IM1       <= (state_nxt == PULSE) &&  shreg_nxt[15];
            IM0       <= (state_nxt == PULSE) && !shreg_nxt[15];
            rdReq     <= (state_nxt == FETCH);
            busy      <= (state_nxt != IDLE) && (state_nxt != DONE);
            frameDone <= (state_nxt == DONE);
            if (state_nxt == FETCH)
                rdAddr <= wordCnt_nxt;
            else if (state_nxt == IDLE)
                rdAddr <= '0;
        end
    end

endmodule

// File: tb/tb_bcd_frame_transmitter.sv
// Directed bench for bcd_frame_transmitter with shortened frame parameters; a line monitor
// decodes IM1/IM0 pulses back into words and records event times.
module tb_bcd_frame_transmitter;

    localparam int WORDS     = 4;
    localparam int HO_LEN    = 3;
    localparam int PULSE_LEN = 2;
    localparam int GAP_LEN   = 2;
    localparam int WORD_T    = 2 + 16 * (PULSE_LEN + GAP_LEN);       // 66
    localparam int FETCH0    = 1 + HO_LEN + GAP_LEN;                 // 6
    localparam int FRAME     = FETCH0 + WORDS * WORD_T;              // 270

    logic        clk13MHz = 1'b0;
    logic        nRST = 1'b1;
    logic        start = 1'b0;
    logic [15:0] din;
    logic        rdReq;
    logic [6:0]  rdAddr;
    logic        HO, IM1, IM0, busy, frameDone;

    always #5 clk13MHz = ~clk13MHz;

    bcd_frame_transmitter #(
        .WORDS(WORDS), .HO_LEN(HO_LEN), .PULSE_LEN(PULSE_LEN), .GAP_LEN(GAP_LEN)
    ) dut (
        .clk13MHz (clk13MHz),
        .nRST     (nRST),
        .start    (start),
        .din      (din),
        .rdReq    (rdReq),
        .rdAddr   (rdAddr),
        .HO       (HO),
        .IM1      (IM1),
        .IM0      (IM0),
        .busy     (busy),
        .frameDone(frameDone)
    );

    // Word store: data valid the cycle after rdReq, garbage otherwise.
    logic [15:0] store [128];
    always @(posedge clk13MHz) din <= rdReq ? store[rdAddr] : 16'($urandom);

    int cyc = 0;
    always @(posedge clk13MHz) cyc <= cyc + 1;

    int          both_err, ho_err, plen_err, ps_cnt, ps0, ps1, ho_rise, ho_fall;
    int          rd_cnt, rd_first, fd_cnt, fd_cyc, run, nb;
    logic [6:0]  rd_first_addr;
    logic [15:0] sh;
    logic        bit_v, ho_p = 1'b0, im_p = 1'b0;
    logic [15:0] dec_q [$];

    always @(posedge clk13MHz) begin
        #1;
        if (IM1 && IM0) both_err++;
        if (HO && (IM1 || IM0)) ho_err++;
        if (HO && !ho_p) ho_rise = cyc;
        if (!HO && ho_p) ho_fall = cyc;
        if (rdReq) begin
            rd_cnt++;
            if (rd_cnt == 1) begin
                rd_first      = cyc;
                rd_first_addr = rdAddr;
            end
        end
        if (frameDone) begin
            fd_cnt++;
            fd_cyc = cyc;
        end
        if ((IM1 || IM0) && !im_p) begin
            run   = 1;
            bit_v = IM1;
            if (ps_cnt == 0) ps0 = cyc;
            if (ps_cnt == 1) ps1 = cyc;
            ps_cnt++;
        end else if (IM1 || IM0) begin
            run++;
        end
        if (!(IM1 || IM0) && im_p) begin
            if (run != PULSE_LEN) plen_err++;
            sh = {sh[14:0], bit_v};
            nb++;
            if (nb == 16) begin
                dec_q.push_back(sh);
                nb = 0;
            end
        end
        ho_p = HO;
        im_p = IM1 || IM0;
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_mon();
        both_err = 0; ho_err = 0; plen_err = 0; ps_cnt = 0; ps0 = 0; ps1 = 0;
        ho_rise = 0; ho_fall = 0; rd_cnt = 0; rd_first = 0; rd_first_addr = '0;
        fd_cnt = 0; fd_cyc = 0; run = 0; nb = 0; sh = '0;
        dec_q.delete();
    endtask

    task automatic wait_done(input int limit);
        int n;
        n = 0;
        while (!frameDone && n < limit) begin
            @(negedge clk13MHz);
            n++;
        end
    endtask

    int t0, t1, n, idle_bad;

    initial begin
        clear_mon();
        // Reset and quiet idle
        repeat (3) @(negedge clk13MHz);
        chk("rst_HO", HO, 0);
        chk("rst_IM1", IM1, 0);
        chk("rst_IM0", IM0, 0);
        chk("rst_rdReq", rdReq, 0);
        chk("rst_busy", busy, 0);
        chk("rst_frameDone", frameDone, 0);
        chk("rst_rdAddr", rdAddr, 0);
        nRST = 1'b0;
        idle_bad = 0;
        repeat (1000) begin
            @(negedge clk13MHz);
            if (HO || IM1 || IM0 || rdReq || busy || frameDone) idle_bad++;
        end
        chk("idle_quiet", idle_bad, 0);

        // Frame 1: store[k]=k, stray start mid-frame and in the DONE cycle
        for (int k = 0; k < WORDS; k++) store[k] = 16'(k);
        clear_mon();
        start = 1'b1;
        t0 = cyc;
        @(negedge clk13MHz);
        start = 1'b0;
        chk("busy_t1", busy, 1);
        n = 0;
        while (!frameDone && n < 2 * FRAME) begin
            @(negedge clk13MHz);
            n++;
            start = (cyc == t0 + 100);
        end
        chk("f1_done_seen", frameDone, 1);
        chk("f1_done_time", cyc - t0, FRAME);
        chk("f1_busy_in_done", busy, 0);
        start = 1'b1;
        @(negedge clk13MHz);
        start = 1'b0;
        repeat (10) @(negedge clk13MHz);
        chk("f1_no_restart_busy", busy, 0);
        chk("f1_no_restart_HO", ho_rise - t0, 1);
        chk("f1_rdAddr_idle", rdAddr, 0);
        chk("f1_fd_count", fd_cnt, 1);
        chk("f1_ho_fall", ho_fall - t0, HO_LEN + 1);
        chk("f1_rd_first_t", rd_first - t0, FETCH0);
        chk("f1_rd_first_addr", rd_first_addr, 0);
        chk("f1_rd_count", rd_cnt, WORDS);
        chk("f1_pulse0_t", ps0 - t0, FETCH0 + 2);
        chk("f1_pulse_spacing", ps1 - ps0, PULSE_LEN + GAP_LEN);
        chk("f1_pulse_count", ps_cnt, WORDS * 16);
        chk("f1_pulse_len", plen_err, 0);
        chk("f1_both_high", both_err, 0);
        chk("f1_ho_with_im", ho_err, 0);
        chk("f1_word_count", dec_q.size(), WORDS);
        for (int k = 0; k < WORDS; k++) chk("f1_word", dec_q[k], 32'(k));

        // Frame 2: patterned words, start held high across DONE
        store[0] = 16'hA5A5; store[1] = 16'h8001; store[2] = 16'hFFFF; store[3] = 16'h1234;
        clear_mon();
        start = 1'b1;
        t0 = cyc;
        @(negedge clk13MHz);
        wait_done(2 * FRAME);
        chk("f2_done_time", cyc - t0, FRAME);
        t1 = cyc;
        n = 0;
        while (!HO && n < 20) begin
            @(negedge clk13MHz);
            n++;
        end
        chk("f2_resync_time", cyc - t1, 2);
        chk("f2_word_count", dec_q.size(), WORDS);
        chk("f2_wordA5A5", dec_q[0], 32'h0000A5A5);
        chk("f2_word8001", dec_q[1], 32'h00008001);
        chk("f2_wordFFFF", dec_q[2], 32'h0000FFFF);
        chk("f2_word1234", dec_q[3], 32'h00001234);
        chk("f2_both_high", both_err, 0);
        chk("f2_pulse_len", plen_err, 0);

        // Frame 3: reset during a pulse of word 2
        start = 1'b0;
        clear_mon();
        n = 0;
        while (!(rd_cnt >= 3 && (IM1 || IM0)) && n < 2 * FRAME) begin
            @(negedge clk13MHz);
            n++;
        end
        chk("f3_mid_pulse_reached", IM1 || IM0, 1);
        nRST = 1'b1;
        @(negedge clk13MHz);
        nRST = 1'b0;
        chk("f3_rst_HO", HO, 0);
        chk("f3_rst_IM1", IM1, 0);
        chk("f3_rst_IM0", IM0, 0);
        chk("f3_rst_busy", busy, 0);
        chk("f3_rst_rdAddr", rdAddr, 0);
        repeat (400) @(negedge clk13MHz);
        chk("f3_no_frameDone", fd_cnt, 0);
        chk("f3_still_idle", busy, 0);

        // Frame 4: random words, restart from address 0
        for (int k = 0; k < WORDS; k++) store[k] = 16'($urandom);
        clear_mon();
        start = 1'b1;
        t0 = cyc;
        @(negedge clk13MHz);
        start = 1'b0;
        wait_done(2 * FRAME);
        chk("f4_done_time", cyc - t0, FRAME);
        repeat (5) @(negedge clk13MHz);
        chk("f4_rd_first_addr", rd_first_addr, 0);
        chk("f4_rd_first_t", rd_first - t0, FETCH0);
        chk("f4_fd_count", fd_cnt, 1);
        chk("f4_pulse_len", plen_err, 0);
        chk("f4_word_count", dec_q.size(), WORDS);
        for (int k = 0; k < WORDS; k++) chk("f4_word", dec_q[k], 32'(store[k]));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
